// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, frame length and the sample loader
// state encoding. Imported by fft_sample_loader and the FFT core.
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned N_POINTS   = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    LOAD_EVEN = 2'd0,
    LOAD_ODD  = 2'd1,
    WR_LAST   = 2'd2,
    FULL      = 2'd3
  } loader_state_e;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational W-bit address reversal, shared by the sample loader and the
// FFT core address generator.
//   addr_i  in   W  natural-order index
//   rev_o   out  W  bit-reversed index
module fft_bitrev #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] addr_i,
  output logic [W-1:0] rev_o
);

  always_comb begin
    rev_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      rev_o[i] = addr_i[W-1-i];
    end
  end

endmodule

// File: rtl/fft_sample_loader.sv
// FFT input stage: accepts complex samples on a valid/ready interface, pairs
// even/odd samples and writes both to the dual-port bank RAM in one cycle at
// bit-reversed addresses. Raises frame_full once N samples are stored and
// keeps the RAM ports idle until frame_release.
// Optional build macro: FFT_LOADER_SCALE_EN (arithmetic >>1 of each component).
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   in_valid/in_ready/in_real/in_imag  sample input handshake and data
//   frame_restart, frame_release   sync control pulses
//   frame_full                     bank holds a complete frame
//   ram_A_*  / ram_B_*             port A (even sample) / port B (odd sample) writes
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = $clog2(N_POINTS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              frame_restart,
  input  logic              frame_release,
  output logic              frame_full,
  output logic              ram_A_en,
  output logic [ADDR_W-1:0] ram_A_addr,
  output logic [DATA_W-1:0] ram_A_dataR,
  output logic [DATA_W-1:0] ram_A_dataC,
  output logic              ram_B_en,
  output logic [ADDR_W-1:0] ram_B_addr,
  output logic [DATA_W-1:0] ram_B_dataR,
  output logic [DATA_W-1:0] ram_B_dataC
);

  localparam int unsigned     K_W    = ADDR_W - 1;
  localparam logic [K_W-1:0]  K_ONE  = K_W'(1);
  localparam logic [K_W-1:0]  K_LAST = '1;

  loader_state_e     state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] hold_r_q, hold_i_q;
  logic              a_en_q, b_en_q;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] a_r_q, a_i_q, b_r_q, b_i_q;
  logic              accept, latch_even, pair_wr;
  logic [ADDR_W-1:0] rev_even;

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x);
`ifdef FFT_LOADER_SCALE_EN
    return {x[DATA_W-1], x[DATA_W-1:1]};
`else
    return x;
`endif
  endfunction

  fft_bitrev #(.W(ADDR_W)) u_bitrev (
    .addr_i ({k_q, 1'b0}),
    .rev_o  (rev_even)
  );

  // State register (pair counter and frame_full travel with the state)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_EVEN;
      k_q     <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic; restart overrides every other event
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    full_d  = full_q;
    if (frame_restart) begin
      state_d = LOAD_EVEN;
      k_d     = '0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD_EVEN: if (accept) state_d = LOAD_ODD;
        LOAD_ODD: if (accept) begin
          k_d     = k_q + K_ONE;
          state_d = (k_q == K_LAST) ? WR_LAST : LOAD_EVEN;
        end
        WR_LAST: begin
          state_d = FULL;
          full_d  = 1'b1;
        end
        FULL: if (frame_release) begin
          state_d = LOAD_EVEN;
          k_d     = '0;
          full_d  = 1'b0;
        end
        default: state_d = LOAD_EVEN;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready   = (state_q == LOAD_EVEN) || (state_q == LOAD_ODD);
    accept     = in_valid & in_ready;
    latch_even = accept & (state_q == LOAD_EVEN) & ~frame_restart;
    pair_wr    = accept & (state_q == LOAD_ODD) & ~frame_restart;
  end

  // Holding register and registered RAM write ports. Enables self-clear so a
  // pair write already launched finishes its single cycle even on restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_r_q <= '0;
      hold_i_q <= '0;
      a_en_q   <= 1'b0;
      b_en_q   <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_r_q    <= '0;
      a_i_q    <= '0;
      b_r_q    <= '0;
      b_i_q    <= '0;
    end else begin
      a_en_q <= pair_wr;
      b_en_q <= pair_wr;
      if (latch_even) begin
        hold_r_q <= scale(in_real);
        hold_i_q <= scale(in_imag);
      end else if (frame_restart) begin
        hold_r_q <= '0;
        hold_i_q <= '0;
      end
      if (pair_wr) begin
        a_addr_q <= rev_even;
        a_r_q    <= hold_r_q;
        a_i_q    <= hold_i_q;
        b_addr_q <= rev_even | {1'b1, {(ADDR_W-1){1'b0}}};
        b_r_q    <= scale(in_real);
        b_i_q    <= scale(in_imag);
      end
    end
  end

  assign frame_full  = full_q;
  assign ram_A_en    = a_en_q;
  assign ram_A_addr  = a_addr_q;
  assign ram_A_dataR = a_r_q;
  assign ram_A_dataC = a_i_q;
  assign ram_B_en    = b_en_q;
  assign ram_B_addr  = b_addr_q;
  assign ram_B_dataR = b_r_q;
  assign ram_B_dataC = b_i_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: behavioural bank RAM fed by the write
// ports, bit-reversed golden image, immediate-assertion checks.
module tb_fft_sample_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_real = '0;
  logic [15:0] in_imag = '0;
  logic        frame_restart = 1'b0;
  logic        frame_release = 1'b0;
  logic        frame_full;
  logic        ram_A_en, ram_B_en;
  logic [4:0]  ram_A_addr, ram_B_addr;
  logic [15:0] ram_A_dataR, ram_A_dataC, ram_B_dataR, ram_B_dataC;

  int checks = 0;
  int errors = 0;

  logic [15:0] memR [32];
  logic [15:0] memI [32];
  logic [15:0] gR [32];
  logic [15:0] gI [32];
  int a_cnt = 0, b_cnt = 0, dbl = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  fft_sample_loader #(.DATA_W(16), .ADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .frame_restart(frame_restart),
    .frame_release(frame_release), .frame_full(frame_full),
    .ram_A_en(ram_A_en), .ram_A_addr(ram_A_addr), .ram_A_dataR(ram_A_dataR),
    .ram_A_dataC(ram_A_dataC), .ram_B_en(ram_B_en), .ram_B_addr(ram_B_addr),
    .ram_B_dataR(ram_B_dataR), .ram_B_dataC(ram_B_dataC)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_A_en) begin
      memR[ram_A_addr] <= ram_A_dataR;
      memI[ram_A_addr] <= ram_A_dataC;
      a_cnt <= a_cnt + 1;
    end
    if (ram_B_en) begin
      memR[ram_B_addr] <= ram_B_dataR;
      memI[ram_B_addr] <= ram_B_dataC;
      b_cnt <= b_cnt + 1;
    end
    if ((ram_A_en && prev_a) || (ram_B_en && prev_b)) dbl <= dbl + 1;
    prev_a <= ram_A_en;
    prev_b <= ram_B_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] brev(input logic [4:0] n);
    return {n[0], n[1], n[2], n[3], n[4]};
  endfunction

  function automatic logic [15:0] scl(input logic [15:0] x);
`ifdef FFT_LOADER_SCALE_EN
    return {x[15], x[15:1]};
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] i, input int idx);
    int t = 0;
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = i;
    while (!in_ready && t < 8) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_ready idx=%0d observed=0 expected=1", idx);
    end
    tick();
    gR[brev(5'(idx))] = scl(r);
    gI[brev(5'(idx))] = scl(i);
  endtask

  task automatic wait_full(input string tag);
    int t = 0;
    while (!frame_full && t < 8) begin
      tick();
      t++;
    end
    check(tag, 32'(frame_full), 32'd1);
  endtask

  task automatic check_image(input string tag);
    for (int a = 0; a < 32; a++)
      check($sformatf("%s[%0d]", tag, a), {memR[a], memI[a]}, {gR[a], gI[a]});
  endtask

  task automatic release_frame();
    in_valid = 1'b0;
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  initial begin
    int a0, b0;
    logic [15:0] r;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_full", 32'(frame_full), 32'd0);
    check("rst_A", {ram_A_en, 3'b0, ram_A_addr, ram_A_dataR, 7'b0}, 32'd0);
    check("rst_B", {ram_B_en, 3'b0, ram_B_addr, ram_B_dataR, 7'b0}, 32'd0);
    check("rst_Cdata", {ram_A_dataC, ram_B_dataC}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1/2: continuous stream real=n imag=-n
    for (int n = 0; n < 32; n++) begin
      r = 16'(n);
`ifdef FFT_LOADER_SCALE_EN
      if (n == 30) r = 16'hFFFD;
`endif
      send(r, 16'(-n), n);
      if (n == 1) begin
        check("p01_Aen_addr", {ram_A_en, ram_A_addr}, {1'b1, 5'd0});
        check("p01_Ben_addr", {ram_B_en, ram_B_addr}, {1'b1, 5'd16});
      end
      if (n == 2) check("p01_en_single", {ram_A_en, ram_B_en}, 32'd0);
      if (n == 3) begin
        check("p23_A_addr", 32'(ram_A_addr), 32'd8);
        check("p23_B_addr", 32'(ram_B_addr), 32'd24);
`ifdef FFT_LOADER_SCALE_EN
        check("p23_A_data", {ram_A_dataR, ram_A_dataC}, {16'd1, 16'hFFFF});
        check("p23_B_data", {ram_B_dataR, ram_B_dataC}, {16'd1, 16'hFFFE});
`else
        check("p23_A_data", {ram_A_dataR, ram_A_dataC}, {16'd2, 16'hFFFE});
        check("p23_B_data", {ram_B_dataR, ram_B_dataC}, {16'd3, 16'hFFFD});
`endif
      end
    end
    check("last_B", {ram_B_en, ram_B_addr}, {1'b1, 5'd31});
    check("last_full_lo", 32'(frame_full), 32'd0);
    check("last_ready_lo", 32'(in_ready), 32'd0);
    in_real = 16'd99;
    tick();
    check("full_rise", 32'(frame_full), 32'd1);
    check_image("img1");
`ifdef FFT_LOADER_SCALE_EN
    check("s30_addr15", 32'(memR[15]), 32'h0000FFFE);
`else
    check("s30_addr15", 32'(memR[15]), 32'd30);
`endif

    // 3: held valid while FULL
    a0 = a_cnt;
    b0 = b_cnt;
    for (int c = 0; c < 3; c++) begin
      check("full_hold", {in_ready, ram_A_en, ram_B_en, frame_full}, 32'b0001);
      tick();
    end
    check("full_no_writes", a_cnt + b_cnt, a0 + b0);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check("rel_ready", 32'(in_ready), 32'd1);
    check("rel_full", 32'(frame_full), 32'd0);
    send(16'd100, 16'hFF9C, 0);
    send(16'd101, 16'hFF9B, 1);
    check("rel_A_addr", {ram_A_en, ram_A_addr}, {1'b1, 5'd0});
    check("rel_B_addr", {ram_B_en, ram_B_addr}, {1'b1, 5'd16});
`ifdef FFT_LOADER_SCALE_EN
    check("rel_A_data", {ram_A_dataR, ram_A_dataC}, {16'd50, 16'hFFCE});
`else
    check("rel_A_data", {ram_A_dataR, ram_A_dataC}, {16'd100, 16'hFF9C});
`endif
    in_valid = 1'b0;
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;

    // 4: random valid gaps
    a0 = a_cnt;
    b0 = b_cnt;
    for (int n = 0; n < 32; n++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      send(16'($urandom), 16'($urandom), n);
    end
    in_valid = 1'b0;
    wait_full("gap_full");
    check_image("img_gap");
    check("gap_A_pulses", a_cnt - a0, 32'd16);
    check("gap_B_pulses", b_cnt - b0, 32'd16);
    check("en_single_cycle", dbl, 32'd0);
    release_frame();

    // 5: restart after 13 samples, sample on the restart edge dropped
    for (int n = 0; n < 13; n++) send(16'(n + 200), 16'(n), n);
    frame_restart = 1'b1;
    in_valid = 1'b1;
    in_real = 16'h7777;
    in_imag = 16'h7777;
    tick();
    frame_restart = 1'b0;
    check("rst_pulse_full", 32'(frame_full), 32'd0);
    for (int n = 0; n < 32; n++) begin
      send(16'(n * 3 + 7), 16'(1000 - n), n);
      if (n == 1) begin
        check("rs_A_addr", {ram_A_en, ram_A_addr}, {1'b1, 5'd0});
        check("rs_A_data", {ram_A_dataR, ram_A_dataC}, {scl(16'd7), scl(16'd1000)});
      end
      if (n == 5) begin
        in_valid = 1'b0;
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
      end
      if (n == 30) check("rs_no_early_full", 32'(frame_full), 32'd0);
    end
    in_valid = 1'b0;
    wait_full("rs_full");
    check_image("img_rs");
    release_frame();

    // 6: async reset mid-frame
    for (int n = 0; n < 20; n++) send(16'(n + 500), 16'(n + 600), n);
    in_valid = 1'b0;
    check("pre_rst_A", {ram_A_en, ram_A_addr}, {1'b1, 5'd9});
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_A", {ram_A_en, ram_A_addr, ram_A_dataR}, 32'd0);
    check("arst_B", {ram_B_en, ram_B_addr, ram_B_dataR}, 32'd0);
    check("arst_C", {ram_A_dataC, ram_B_dataC}, 32'd0);
    check("arst_full", 32'(frame_full), 32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    for (int n = 0; n < 32; n++) begin
      send(16'(n + 40), 16'(n + 80), n);
      if (n == 1) check("post_rst_A", {ram_A_en, ram_A_addr, ram_A_dataR}, {1'b1, 5'd0, scl(16'd40)});
    end
    in_valid = 1'b0;
    wait_full("post_rst_full");
    check_image("img_post_rst");
    release_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
